// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_EXC  = 2'd3
  } state_e;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement: passes the value through, or negates it when
// i_neg is set. Used for operand magnitudes and for the final sign correction.
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and restoring divide with HI/LO results.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div, r_neg_lo, r_neg_hi;
  logic [2*WIDTH-1:0]   r_mcand, r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH:0]       r_rem;
  logic                 r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0]     r_hi, r_lo;

  op_e                  w_op;
  logic                 w_sgn, w_last, w_fits, w_eo_start, w_eo_calc;
  logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_quo, w_rem, w_keep;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_op  = op_e'(op);
  assign w_sgn = is_signed_op(w_op);

  cond_negate #(.W(WIDTH)) u_neg_a (
    .i_val(a), .i_neg(w_sgn & a[WIDTH-1]), .o_val(w_a_mag)
  );
  cond_negate #(.W(WIDTH)) u_neg_b (
    .i_val(b), .i_neg(w_sgn & b[WIDTH-1]), .o_val(w_b_mag)
  );
  cond_negate #(.W(2*WIDTH)) u_neg_prod (
    .i_val(r_acc), .i_neg(r_neg_lo), .o_val(w_prod)
  );
  cond_negate #(.W(WIDTH)) u_neg_quo (
    .i_val(r_mplier), .i_neg(r_neg_lo), .o_val(w_quo)
  );
  cond_negate #(.W(WIDTH)) u_neg_rem (
    .i_val(r_rem[WIDTH:1]), .i_neg(r_neg_hi), .o_val(w_rem)
  );

  // r_rem holds the shifted partial remainder; the low bit is the next dividend bit.
  assign w_diff = r_rem - {1'b0, r_mcand[WIDTH-1:0]};
  assign w_fits = ~w_diff[WIDTH];
  assign w_keep = w_fits ? w_diff[WIDTH-1:0] : r_rem[WIDTH-1:0];
  assign w_last = (r_cnt == CW'(WIDTH - 1));

`ifdef MULDIV_EARLY_OUT_EN
  assign w_eo_start = !is_div(w_op) && (w_b_mag == '0);
  assign w_eo_calc  = !r_is_div && ((r_mplier >> 1) == '0);
`else
  assign w_eo_start = 1'b0;
  assign w_eo_calc  = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_div(w_op) && (b == '0)) w_next = ST_EXC;
          else if (w_eo_start)           w_next = ST_FIX;
          else                           w_next = ST_CALC;
        end
      end
      ST_CALC: if (w_last || w_eo_calc) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      ST_EXC:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state    <= w_next;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        ST_CALC: r_cnt <= r_cnt + CW'(1);
        ST_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        ST_EXC: begin
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          r_is_div <= is_div(w_op);
          r_neg_lo <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg_hi <= w_sgn & a[WIDTH-1];
          r_acc    <= '0;
          if (is_div(w_op)) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_b_mag};
            r_mplier <= w_a_mag;
            r_rem    <= {{WIDTH{1'b0}}, w_a_mag[WIDTH-1]};
          end else begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_rem    <= '0;
          end
        end
      end
      ST_CALC: begin
        if (r_is_div) begin
          r_rem    <= {w_keep, r_mplier[WIDTH-2]};
          r_mplier <= {r_mplier[WIDTH-2:0], w_fits};
        end else begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit. It computes signed and unsigned products and quotient/remainder pairs over `WIDTH`-bit operands. It returns the results on the HI/LO pair that feeds the register-bank write-data path. The unit sits beside the ALU and is driven by the control unit through a start/done handshake; it raises a divide-by-zero flag for the exception mux.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; the only reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `a` in `WIDTH`: multiplicand / dividend (driven from A).
- `b` in `WIDTH`: multiplier / divisor (driven from B).
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `div_zero` out 1: one-cycle pulse with `done`, set on DIV/DIVU with `b == 0`.
- `hi` out `WIDTH`: product upper half / remainder.
- `lo` out `WIDTH`: product lower half / quotient.

## Operation
- **States:** IDLE, CALC, FIX, EXC.
- **IDLE with `start = 1`:**
  - Latch `op`, the magnitudes of `a`/`b` (signed ops only), and the two result-sign bits.
  - Clear the iteration counter.
  - Go to CALC, or to EXC if the op is a divide and `b == 0`.
- **CALC, multiply:**
  - The multiplicand sits in a 2·`WIDTH` register that shifts left; the multiplier shifts right.
  - When the multiplier LSB is 1, add the multiplicand register into the 2·`WIDTH` accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first. The remainder register is `WIDTH+1` bits.
- **CALC exit:** CALC runs exactly `WIDTH` iterations, then goes to FIX.
- **FIX:**
  - Apply signs: a signed product is negated when the operand signs differ.
  - The quotient truncates toward zero; the remainder takes the dividend's sign.
  - Register the results into `hi`/`lo`, pulse `done`, return to IDLE.
- **EXC:** pulse `done` and `div_zero`; leave `hi`/`lo` unchanged; return to IDLE.
- **Arithmetic rules:**
  - All arithmetic is modulo 2^`WIDTH` per half.
  - DIV of the most-negative value by -1 gives LO = most-negative and HI = 0, with no flag.
  - MULTU/DIVU ignore sign bits.
- **`start` while busy:** ignored; no queueing.
- **Outputs:** `hi`/`lo` hold their values between operations and change only at the FIX edge.

## Timing
- **Reset values:** `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, state IDLE, counter 0.
- **Edge numbering:** edge 0 is the edge that samples `start`.
  - `busy` is high from after edge 0 until the FIX edge.
  - `done` is high for exactly the one cycle after the FIX edge (or the EXC edge).
- **Latency:** normal ops put `done` after edge `WIDTH+1`; divide-by-zero puts `done` after edge 1.
- **Back-to-back:** `start` asserted in the same cycle as `done` is accepted, because the state is already IDLE.
- **Reset mid-operation:** abort immediately; all outputs take their reset values; no `done`.
- **Timing path:** no combinational path from inputs to outputs.

## Configuration
- **`MULDIV_EARLY_OUT_EN` defined:**
  - For MULT/MULTU, the remaining multiplier register is checked at edge 0 and after each iteration.
  - When it is zero, the next state is FIX, so latency = (index of the highest set multiplier-magnitude bit + 1) + 1 edges.
  - A zero multiplier goes to FIX at edge 1.
  - Divide latency is unchanged.
- **Not defined:** every MULT/MULTU takes exactly `WIDTH` CALC iterations.

## Structure
- **Package `muldiv_pkg`:**
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`.
  - State encoding `ST_IDLE`, `ST_CALC`, `ST_FIX`, `ST_EXC`.
- **Sub-module `cond_negate`:** parametrised-width conditional two's-complement, used for operand magnitudes and the FIX sign correction.
- **Control:** state register and counter stay in `muldiv_unit`.

## Test plan
All scenarios use `WIDTH` = 32 and the macro undefined unless stated.
- **MULT:** a = 0xFFFFFFFD, b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; `done` after edge 33; `busy` high for 33 cycles.
- **MULTU:** a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- **DIV / DIVU:**
  - DIV a = 0xFFFFFFF9 (-7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU a = 7, b = 2 → lo = 3, hi = 1.
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- **Divide by zero:** DIV with b = 0 after a prior result of hi = 1, lo = 3 → `done` and `div_zero` after edge 1; hi/lo stay 1/3.
- **Busy and reset:**
  - `start` re-pulsed at edge 5 of a running op → ignored; the first op's result arrives at edge 33.
  - Reset asserted at edge 10 → all outputs 0 immediately; no `done`.
- **Early out, macro defined:**
  - MULTU 5 × 3 → lo = 15, hi = 0, `done` after edge 3.
  - MULTU 5 × 0 → lo = 0, `done` after edge 1.
